// File: rtl/p2s_sda_tx_if.sv
// Handshake and serial-link signals of the scl/sda nibble transmitter.
// The master side supplies nibbles; the slave side is the transmitter.
interface p2s_sda_tx_if;
    logic [3:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       busy;
    logic       scl;
    logic       sda;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  busy,
        input  scl,
        input  sda
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output busy,
        output scl,
        output sda
    );
endinterface

// File: rtl/p2s_sda_tx.sv
// Nibble transmitter: prime pulse after reset, then framed transfers of
// start, 4 data bits MSB first, one trailer clock with sda low, and stop.
module p2s_sda_tx #(
    parameter int HALF = 4
) (
    input  logic          clk,
    input  logic          rst,
    p2s_sda_tx_if.slave   bus
);

    typedef enum logic [3:0] {
        S_RESET,
        S_PRIME_L,
        S_PRIME_H,
        S_IDLE,
        S_START,
        S_BIT_L,
        S_BIT_H,
        S_TRL_L,
        S_TRL_H,
        S_STOP
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] phase_reg, phase_next;
    logic [1:0] bit_reg, bit_next;
    logic [3:0] shift_reg, shift_next;
    logic       scl_reg, scl_next;
    logic       sda_reg, sda_next;
    logic       ready_reg, ready_next;
    logic       busy_reg, busy_next;
    logic       phase_done;

    assign phase_done = (phase_reg == 8'(HALF - 1));

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;

        case (state_reg)
            S_RESET: begin
                state_next = S_PRIME_L;
                phase_next = 8'd0;
            end
            S_IDLE: begin
                // ready is high in IDLE, so valid alone completes the handshake
                if (bus.din_valid) begin
                    state_next = S_START;
                    shift_next = bus.din;
                    bit_next   = 2'd3;
                    phase_next = 8'd0;
                end
            end
            default: begin
                if (phase_done) begin
                    phase_next = 8'd0;
                    case (state_reg)
                        S_PRIME_L: state_next = S_PRIME_H;
                        S_PRIME_H: state_next = S_IDLE;
                        S_START:   state_next = S_BIT_L;
                        S_BIT_L:   state_next = S_BIT_H;
                        S_BIT_H: begin
                            if (bit_reg == 2'd0) begin
                                state_next = S_TRL_L;
                            end else begin
                                state_next = S_BIT_L;
                                bit_next   = bit_reg - 2'd1;
                                shift_next = {shift_reg[2:0], 1'b0};
                            end
                        end
                        S_TRL_L:   state_next = S_TRL_H;
                        S_TRL_H:   state_next = S_STOP;
                        S_STOP:    state_next = S_IDLE;
                        default:   state_next = S_RESET;
                    endcase
                end else begin
                    phase_next = phase_reg + 8'd1;
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        scl_next   = 1'b1;
        sda_next   = 1'b1;
        ready_next = 1'b0;
        busy_next  = 1'b0;
        case (state_next)
            S_PRIME_L: scl_next = 1'b0;
            S_IDLE:    ready_next = 1'b1;
            S_START: begin
                sda_next  = 1'b0;
                busy_next = 1'b1;
            end
            S_BIT_L: begin
                scl_next  = 1'b0;
                sda_next  = shift_next[3];
                busy_next = 1'b1;
            end
            S_BIT_H: begin
                sda_next  = shift_next[3];
                busy_next = 1'b1;
            end
            S_TRL_L: begin
                scl_next  = 1'b0;
                sda_next  = 1'b0;
                busy_next = 1'b1;
            end
            S_TRL_H: begin
                sda_next  = 1'b0;
                busy_next = 1'b1;
            end
            S_STOP:    busy_next = 1'b1;
            default: begin
                scl_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_RESET;
            phase_reg <= 8'd0;
            bit_reg   <= 2'd0;
            shift_reg <= 4'd0;
            scl_reg   <= 1'b1;
            sda_reg   <= 1'b1;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            scl_reg   <= scl_next;
            sda_reg   <= sda_next;
            ready_reg <= ready_next;
            busy_reg  <= busy_next;
        end
    end

    assign bus.scl       = scl_reg;
    assign bus.sda       = sda_reg;
    assign bus.din_ready = ready_reg;
    assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_p2s_sda_tx.sv
// Directed bench for p2s_sda_tx at HALF=4 and HALF=2 with a behavioural
// scl/sda receiver that decodes each nibble d to one-hot bit (d-1) mod 16.
module tb_p2s_sda_tx;

    logic       clk = 1'b0;
    logic       rst4 = 1'b1;
    logic       rst2 = 1'b1;
    logic [3:0] din = 4'd0;
    logic       din_valid = 1'b0;
    logic       sel = 1'b0;

    always #5 clk = ~clk;

    p2s_sda_tx_if if4 ();
    p2s_sda_tx_if if2 ();

    assign if4.din       = din;
    assign if4.din_valid = din_valid;
    assign if2.din       = din;
    assign if2.din_valid = din_valid;

    p2s_sda_tx #(.HALF(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4.slave));
    p2s_sda_tx #(.HALF(2)) dut2 (.clk(clk), .rst(rst2), .bus(if2.slave));

    logic m_scl, m_sda, m_rdy, m_busy;
    assign m_scl  = sel ? if2.scl : if4.scl;
    assign m_sda  = sel ? if2.sda : if4.sda;
    assign m_rdy  = sel ? if2.din_ready : if4.din_ready;
    assign m_busy = sel ? if2.busy : if4.busy;

    int checks = 0;
    int errors = 0;

    // Receiver model: start/stop detection with scl high, bits on scl rise.
    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    logic        in_frame = 1'b0;
    logic [4:0]  bits = 5'd0;
    int          nbits = 0;
    int          starts = 0;
    int          frames = 0;
    logic [15:0] mon_out = 16'd0;

    always @(posedge clk) begin
        prev_scl <= m_scl;
        prev_sda <= m_sda;
        if (prev_scl && m_scl && prev_sda && !m_sda) begin
            in_frame <= 1'b1;
            nbits    <= 0;
            starts   <= starts + 1;
        end else if (in_frame && !prev_scl && m_scl) begin
            bits  <= {bits[3:0], m_sda};
            nbits <= nbits + 1;
        end else if (in_frame && prev_scl && m_scl && !prev_sda && m_sda) begin
            in_frame <= 1'b0;
            if (nbits == 5 && bits[0] == 1'b0) begin
                mon_out <= 16'h0001 << (bits[4:1] - 4'd1);
                frames  <= frames + 1;
            end
        end
    end

    logic        cap_scl  [0:127];
    logic        cap_sda  [0:127];
    logic        cap_rdy  [0:127];
    logic        cap_busy [0:127];
    logic [15:0] cap_out  [0:127];

    // Records cycles 1..n after a handshake edge, sampled on the falling edge.
    task automatic capture(input int n, input int drop_at, input int chg_at,
                           input logic [3:0] chg_val);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            cap_scl[c]  = m_scl;
            cap_sda[c]  = m_sda;
            cap_rdy[c]  = m_rdy;
            cap_busy[c] = m_busy;
            cap_out[c]  = mon_out;
            if (c == drop_at) din_valid = 1'b0;
            if (c == chg_at) din = chg_val;
        end
    endtask

    // Waits (bounded) for ready, then presents d so the next rising edge is edge 0.
    task automatic handshake(input logic [3:0] d);
        int t = 0;
        while (m_rdy !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (m_rdy !== 1'b1) begin
            $display("FAIL handshake_wait din_ready=%b required=1", m_rdy);
            errors++;
        end
        din = d;
        din_valid = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset;
        int s0;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_scl, m_sda, m_rdy, m_busy} !== 4'b1100) begin
            $display("FAIL reset_outputs scl/sda/rdy/busy=%b required=1100",
                     {m_scl, m_sda, m_rdy, m_busy});
            errors++;
        end
        rst4 = 1'b0;
        s0 = starts;
        @(posedge clk);
        capture(10, 0, 0, 4'h0);
        for (int c = 1; c <= 9; c++) begin
            checks++;
            if (cap_scl[c] !== (c >= 5) || cap_sda[c] !== 1'b1 || cap_rdy[c] !== (c == 9)) begin
                $display("FAIL prime_cycle%0d scl/sda/rdy=%b%b%b required=%b1%b",
                         c, cap_scl[c], cap_sda[c], cap_rdy[c], c >= 5, c == 9);
                errors++;
            end
        end
        checks++;
        if (starts !== s0) begin
            $display("FAIL prime_no_start starts=%0d required=%0d", starts, s0);
            errors++;
        end
    endtask

    task automatic test_single_frame;
        int h = 4;
        int cyc;
        logic [3:0] d = 4'b1010;
        handshake(d);
        capture(12 * h + 1, 1, 0, 4'h0);
        checks++;
        if (cap_scl[1] !== 1'b1 || cap_sda[1] !== 1'b0 || cap_busy[1] !== 1'b1 || cap_rdy[1] !== 1'b0) begin
            $display("FAIL start_c1 scl/sda/busy/rdy=%b%b%b%b required=1010",
                     cap_scl[1], cap_sda[1], cap_busy[1], cap_rdy[1]);
            errors++;
        end
        for (int i = 0; i < 4; i++) begin
            cyc = 2 * h * (i + 1) + 1;
            checks++;
            if (cap_scl[cyc-1] !== 1'b0 || cap_scl[cyc] !== 1'b1 || cap_sda[cyc] !== d[3-i]) begin
                $display("FAIL bit%0d_rise_c%0d scl_before/scl/sda=%b%b%b required=01%b",
                         3 - i, cyc, cap_scl[cyc-1], cap_scl[cyc], cap_sda[cyc], d[3-i]);
                errors++;
            end
        end
        cyc = 10 * h + 1;
        checks++;
        if (cap_scl[cyc-1] !== 1'b0 || cap_scl[cyc] !== 1'b1 || cap_sda[cyc] !== 1'b0) begin
            $display("FAIL trailer_c%0d scl_before/scl/sda=%b%b%b required=010",
                     cyc, cap_scl[cyc-1], cap_scl[cyc], cap_sda[cyc]);
            errors++;
        end
        cyc = 11 * h + 1;
        checks++;
        if (cap_sda[cyc-1] !== 1'b0 || cap_sda[cyc] !== 1'b1 || cap_scl[cyc-1] !== 1'b1 || cap_scl[cyc] !== 1'b1) begin
            $display("FAIL stop_c%0d sda_before/sda/scl_before/scl=%b%b%b%b required=0111",
                     cyc, cap_sda[cyc-1], cap_sda[cyc], cap_scl[cyc-1], cap_scl[cyc]);
            errors++;
        end
        cyc = 12 * h + 1;
        checks++;
        if (cap_rdy[cyc-1] !== 1'b0 || cap_rdy[cyc] !== 1'b1 || cap_busy[cyc-1] !== 1'b1 || cap_busy[cyc] !== 1'b0) begin
            $display("FAIL ready_c%0d rdy_before/rdy/busy_before/busy=%b%b%b%b required=0110",
                     cyc, cap_rdy[cyc-1], cap_rdy[cyc], cap_busy[cyc-1], cap_busy[cyc]);
            errors++;
        end
        checks++;
        if (cap_out[cyc] !== 16'h0200) begin
            $display("FAIL single_outhigh got=%h required=0200", cap_out[cyc]);
            errors++;
        end
    endtask

    task automatic test_boundary;
        logic [3:0]  d;
        logic [15:0] exp_out;
        int f0;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin d = 4'h0; exp_out = 16'h8000; end
                1:       begin d = 4'hF; exp_out = 16'h4000; end
                default: begin d = 4'h1; exp_out = 16'h0001; end
            endcase
            f0 = frames;
            handshake(d);
            capture(49, 1, 0, 4'h0);
            checks++;
            if (cap_out[49] !== exp_out || frames !== f0 + 1) begin
                $display("FAIL boundary_din%h outhigh=%h frames=%0d required=%h frames=%0d",
                         d, cap_out[49], frames, exp_out, f0 + 1);
                errors++;
            end
        end
    endtask

    task automatic test_back_to_back;
        handshake(4'h3);
        capture(98, 50, 1, 4'hC);
        checks++;
        if (cap_out[49] !== 16'h0004) begin
            $display("FAIL b2b_first_outhigh got=%h required=0004", cap_out[49]);
            errors++;
        end
        checks++;
        if (cap_scl[48] !== 1'b1 || cap_sda[48] !== 1'b1 || cap_rdy[48] !== 1'b0) begin
            $display("FAIL b2b_stop_c48 scl/sda/rdy=%b%b%b required=110",
                     cap_scl[48], cap_sda[48], cap_rdy[48]);
            errors++;
        end
        checks++;
        if (cap_rdy[49] !== 1'b1 || cap_busy[49] !== 1'b0 || cap_sda[49] !== 1'b1) begin
            $display("FAIL b2b_idle_c49 rdy/busy/sda=%b%b%b required=101",
                     cap_rdy[49], cap_busy[49], cap_sda[49]);
            errors++;
        end
        checks++;
        if (cap_scl[50] !== 1'b1 || cap_sda[50] !== 1'b0 || cap_busy[50] !== 1'b1 || cap_rdy[50] !== 1'b0) begin
            $display("FAIL b2b_start_c50 scl/sda/busy/rdy=%b%b%b%b required=1010",
                     cap_scl[50], cap_sda[50], cap_busy[50], cap_rdy[50]);
            errors++;
        end
        checks++;
        if (cap_out[98] !== 16'h0800 || cap_rdy[98] !== 1'b1) begin
            $display("FAIL b2b_second outhigh=%h rdy=%b required=0800 rdy=1",
                     cap_out[98], cap_rdy[98]);
            errors++;
        end
    endtask

    task automatic test_din_toggle;
        logic [3:0] exp_bits = 4'h6;
        handshake(4'h6);
        capture(49, 1, 3, 4'h9);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_sda[8*(i+1)+1] !== exp_bits[3-i]) begin
                $display("FAIL toggle_bit%0d sda=%b required=%b",
                         3 - i, cap_sda[8*(i+1)+1], exp_bits[3-i]);
                errors++;
            end
        end
        checks++;
        if (cap_out[49] !== 16'h0020) begin
            $display("FAIL toggle_outhigh got=%h required=0020", cap_out[49]);
            errors++;
        end
    endtask

    task automatic test_reset_midframe;
        int f0;
        int s0;
        f0 = frames;
        handshake(4'hB);
        capture(20, 1, 0, 4'h0);
        rst4 = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_scl, m_sda, m_rdy, m_busy} !== 4'b1100) begin
            $display("FAIL midreset_next scl/sda/rdy/busy=%b required=1100",
                     {m_scl, m_sda, m_rdy, m_busy});
            errors++;
        end
        rst4 = 1'b0;
        s0 = starts;
        capture(9, 0, 0, 4'h0);
        checks++;
        if (cap_scl[1] !== 1'b0 || cap_scl[4] !== 1'b0 || cap_scl[5] !== 1'b1 || cap_rdy[8] !== 1'b0 || cap_rdy[9] !== 1'b1) begin
            $display("FAIL midreset_prime scl1/scl4/scl5/rdy8/rdy9=%b%b%b%b%b required=00101",
                     cap_scl[1], cap_scl[4], cap_scl[5], cap_rdy[8], cap_rdy[9]);
            errors++;
        end
        checks++;
        if (starts !== s0) begin
            $display("FAIL midreset_no_start starts=%0d required=%0d", starts, s0);
            errors++;
        end
        handshake(4'h7);
        capture(49, 1, 0, 4'h0);
        checks++;
        if (cap_out[49] !== 16'h0040 || frames !== f0 + 1) begin
            $display("FAIL midreset_next_frame outhigh=%h frames=%0d required=0040 frames=%0d",
                     cap_out[49], frames, f0 + 1);
            errors++;
        end
    endtask

    task automatic test_min_divider;
        logic [3:0] d = 4'h9;
        int cyc;
        rst4 = 1'b1;
        sel  = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        handshake(d);
        capture(25, 1, 0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            cyc = 4 * (i + 1) + 1;
            checks++;
            if (cap_scl[cyc-1] !== 1'b0 || cap_scl[cyc] !== 1'b1 || cap_sda[cyc] !== d[3-i]) begin
                $display("FAIL half2_bit%0d_c%0d scl_before/scl/sda=%b%b%b required=01%b",
                         3 - i, cyc, cap_scl[cyc-1], cap_scl[cyc], cap_sda[cyc], d[3-i]);
                errors++;
            end
        end
        checks++;
        if (cap_rdy[24] !== 1'b0 || cap_rdy[25] !== 1'b1) begin
            $display("FAIL half2_ready rdy24/rdy25=%b%b required=01", cap_rdy[24], cap_rdy[25]);
            errors++;
        end
        checks++;
        if (cap_out[25] !== 16'h0100) begin
            $display("FAIL half2_outhigh got=%h required=0100", cap_out[25]);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_boundary();
        test_back_to_back();
        test_din_toggle();
        test_reset_midframe();
        test_min_divider();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/p2s_sda_tx.md
# p2s_sda_tx

Parallel-to-serial transmitter for the two-wire scl/sda nibble link. It accepts a 4-bit word over a valid/ready handshake and serialises it as a framed transfer: start condition, 4 data bits MSB first, one trailer clock, stop condition. It drives the link into the existing serial receiver, which decodes each nibble to a 16-bit one-hot output, and it is the stimulus side of the P2S verification environment.

## Interface
- `HALF`, default 4: number of clk cycles per scl half-period (one "phase"); legal range 2..255.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `din` in 4: nibble to send; captured on handshake.
- `din_valid` in 1: `din` holds valid data.
- `din_ready` out 1: block can accept; a handshake occurs on an edge where `din_valid && din_ready`.
- `busy` out 1: a frame is in progress, from START through STOP.
- `scl` out 1: serial clock; idles high.
- `sda` out 1: serial data; idles high. Push-pull, no tri-state.

## Operation
- All outputs are registered.
- **Reset values** while `rst` is high: `scl`=1, `sda`=1, `din_ready`=0, `busy`=0, shift register 0, phase counter 0.
- **States:**
  - PRIME_L: scl=0, sda=1.
  - PRIME_H: scl=1, sda=1.
  - IDLE: scl=1, sda=1, din_ready=1.
  - START: scl=1, sda=0.
  - BIT_L(i): scl=0, sda=d[i].
  - BIT_H(i): scl=1, sda=d[i].
  - TRL_L: scl=0, sda=0.
  - TRL_H: scl=1, sda=0.
  - STOP: scl=1, sda=1.
- Every state except IDLE lasts exactly HALF cycles, counted by the phase counter. IDLE lasts until a handshake.
- **Transitions:**
  - First edge with `rst` low goes to PRIME_L.
  - PRIME_L → PRIME_H → IDLE.
  - IDLE → START on handshake. `din` is latched at that edge, and `din_ready`=0 and `busy`=1 from the next cycle.
  - START → BIT_L(3) → BIT_H(3) → BIT_L(2) → … → BIT_H(0) → TRL_L → TRL_H → STOP → IDLE.
  - `busy` drops and `din_ready` rises in the same cycle that IDLE is entered.
- **Prime pulse:** one scl pulse with sda held high. It places the receiver's bit counter in its initial state without generating a start condition. It runs after every reset and never otherwise.
- `sda` changes only while scl is low, except for two intentional changes with scl high: the fall entering START and the rise entering STOP.
- **Trailer clock:** the scl rising edge in TRL_H, with sda low, advances the receiver from its last data bit to its stop-wait state.
- `din` and `din_valid` are ignored outside IDLE. Changes to `din` mid-frame do not affect the frame in flight.
- **Back-to-back:** if `din_valid` is held high, the next handshake happens on the first IDLE cycle. STOP (sda rises, scl high) is followed directly by START (sda falls, scl high), with IDLE lasting exactly 1 cycle.
- **Reset mid-frame:**
  - On the next edge, `scl`=1 and `sda`=1, `din_ready`=0, `busy`=0.
  - The partial frame is discarded and not retried.
  - The prime pulse is re-executed before IDLE.

## Timing
- Handshake at edge 0. Cycle n means the cycle after edge n.
- Phase k (k=0 for START) occupies cycles k·HALF+1 .. (k+1)·HALF.
- Total frame length is 12 phases:
  - START: 1 phase
  - data bits: 8 phases
  - trailer: 2 phases
  - STOP: 1 phase
- scl rising edges for bits 3,2,1,0 occur at cycles 2·HALF+1, 4·HALF+1, 6·HALF+1 and 8·HALF+1. The trailer rising edge is at 10·HALF+1.
- sda rises (stop) at 11·HALF+1. `din_ready`=1 at 12·HALF+1.
- Data setup to the scl rise is HALF cycles; hold after it is HALF cycles.
- Reset to first `din_ready`: rst released at edge 0 → PRIME_L from cycle 1 → `din_ready`=1 at cycle 2·HALF+1.
- Maximum throughput: one nibble per 12·HALF+1 cycles.

## Test plan
- **Reset and prime, HALF=4:** rst 3 cycles then release → scl=0 on cycles 1–4, scl=1 from 5, sda=1 throughout, `din_ready`=1 at cycle 9, no start condition detected.
- **Single frame, din=4'b1010, HALF=4:** expected waveform:
  - sda falls at cycle 1.
  - scl rises at 9/17/25/33 with sda=1/0/1/0.
  - Trailer edge at 41 with sda=0.
  - Stop at 45.
  - `din_ready` at 49.
  - Receiver outhigh=16'h0200.
- **Boundary values:** din=4'h0 → outhigh=16'h8000; din=4'hF → outhigh=16'h4000; din=4'h1 → outhigh=16'h0001.
- **Back-to-back, `din_valid` held:** send 4'h3 then 4'hC → STOP immediately followed by START, idle exactly 1 cycle, outhigh 16'h0004 then 16'h0800.
- **Mid-frame robustness:** toggle `din` during a frame → serialised bits unchanged. Assert rst at cycle 20 of a frame → scl=sda=1 next cycle, prime re-run, next frame with 4'h7 gives outhigh=16'h0040.
- **Minimum divider, HALF=2:** 4'h9 → scl rises at cycles 5/9/13/17, `din_ready` at 25, outhigh=16'h0100.
